// File: rtl/zeroheti_prio_ic.sv
// zeroHETI priority interrupt controller: per-line priority, enable and trigger mode,
// a software threshold and a hardware nesting stack behind a single-cycle register port.
module zeroheti_prio_ic #(
  parameter int unsigned NrIrqs    = 32,
  parameter int unsigned NrPrios   = 8,
  parameter int unsigned NestDepth = 4,
  localparam int unsigned IrqWidth  = $clog2(NrIrqs),
  localparam int unsigned PrioWidth = $clog2(NrPrios)
) (
  input  logic                 clk_i,
  input  logic                 rst_i,
  input  logic [NrIrqs-1:0]    ext_irqs_i,
  input  logic                 reg_req_i,
  input  logic                 reg_we_i,
  input  logic [11:0]          reg_addr_i,
  input  logic [31:0]          reg_wdata_i,
  output logic                 reg_gnt_o,
  output logic                 reg_rvalid_o,
  output logic [31:0]          reg_rdata_o,
  output logic                 irq_valid_o,
  output logic [IrqWidth-1:0]  irq_id_o,
  output logic [PrioWidth-1:0] irq_level_o,
  output logic                 irq_nest_o,
  input  logic                 irq_ack_i,
  input  logic [IrqWidth-1:0]  irq_id_i,
  input  logic                 irq_ret_i
);
  localparam int unsigned DepthWidth = $clog2(NestDepth + 1);

  logic [PrioWidth-1:0]  prio_r [NrIrqs];
  logic [NrIrqs-1:0]     en_r, pend_r, trig_r, prev_r;
  logic [PrioWidth-1:0]  thresh_r, level_r;
  logic [DepthWidth-1:0] depth_r;
  logic [PrioWidth-1:0]  stack_r [NestDepth];

  logic                  wr_s, rd_s, line_space_s, thresh_sel_s, status_sel_s;
  logic [8:0]            line_idx_s;
  logic                  ack_s, ret_s;
  logic [NrIrqs-1:0]     line_wr_s, ack_line_s, hw_set_s, pend_nxt_s;
  logic [PrioWidth-1:0]  eff_s, best_prio_s, top_s;
  logic [IrqWidth-1:0]   best_id_s;
  logic                  found_s, arb_valid_s;
  logic [31:0]           rd_val_s;

  assign reg_gnt_o    = reg_req_i;
  assign wr_s         = reg_req_i & reg_we_i;
  assign rd_s         = reg_req_i & ~reg_we_i;
  assign line_space_s = ~reg_addr_i[11] & (reg_addr_i[1:0] == 2'b00);
  assign thresh_sel_s = (reg_addr_i == 12'h800);
  assign status_sel_s = (reg_addr_i == 12'h804);
  assign line_idx_s   = reg_addr_i[10:2];
  assign ack_s        = irq_ack_i & irq_valid_o & (irq_id_i == irq_id_o);
  assign ret_s        = irq_ret_i & (depth_r != {DepthWidth{1'b0}});
  // Edge lines only set when the previous sample was low; level lines set whenever high.
  assign hw_set_s     = ext_irqs_i & ~(trig_r & prev_r);
  assign eff_s        = (thresh_r > level_r) ? thresh_r : level_r;

  // Per-line write strobes, ack clears and pending next-state (write > hw set > ack).
  always_comb begin
    line_wr_s  = {NrIrqs{1'b0}};
    ack_line_s = {NrIrqs{1'b0}};
    pend_nxt_s = pend_r;
    for (int i = 0; i < NrIrqs; i++) begin
      line_wr_s[i]  = wr_s & line_space_s & ({23'd0, line_idx_s} == 32'(i));
      ack_line_s[i] = ack_s & (irq_id_o == IrqWidth'(i));
      if (line_wr_s[i]) begin
        pend_nxt_s[i] = reg_wdata_i[9];
      end else if (hw_set_s[i]) begin
        pend_nxt_s[i] = 1'b1;
      end else if (ack_line_s[i]) begin
        pend_nxt_s[i] = 1'b0;
      end else begin
        pend_nxt_s[i] = pend_r[i];
      end
    end
  end

  // Arbitration: strict '>' keeps the lowest index on priority ties.
  always_comb begin
    found_s     = 1'b0;
    best_prio_s = {PrioWidth{1'b0}};
    best_id_s   = {IrqWidth{1'b0}};
    for (int i = 0; i < NrIrqs; i++) begin
      if (en_r[i] && pend_r[i] && (prio_r[i] > eff_s) && (!found_s || (prio_r[i] > best_prio_s))) begin
        found_s     = 1'b1;
        best_prio_s = prio_r[i];
        best_id_s   = IrqWidth'(i);
      end else begin
        found_s     = found_s;
      end
    end
    arb_valid_s = found_s & (depth_r != DepthWidth'(NestDepth));
  end

  // Top-of-stack entry and register read mux.
  always_comb begin
    top_s    = {PrioWidth{1'b0}};
    rd_val_s = 32'd0;
    for (int j = 0; j < NestDepth; j++) begin
      top_s = (depth_r == DepthWidth'(j + 1)) ? stack_r[j] : top_s;
    end
    if (line_space_s) begin
      for (int i = 0; i < NrIrqs; i++) begin
        if ({23'd0, line_idx_s} == 32'(i)) begin
          rd_val_s[PrioWidth-1:0] = prio_r[i];
          rd_val_s[8]             = en_r[i];
          rd_val_s[9]             = pend_r[i];
          rd_val_s[10]            = trig_r[i];
        end else begin
          rd_val_s = rd_val_s;
        end
      end
    end else if (thresh_sel_s) begin
      rd_val_s[PrioWidth-1:0] = thresh_r;
    end else if (status_sel_s) begin
      rd_val_s[PrioWidth-1:0] = level_r;
      rd_val_s[23:16]         = 8'(depth_r);
    end else begin
      rd_val_s = 32'd0;
    end
  end

  // Line configuration, pending state, edge history and threshold.
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      en_r     <= {NrIrqs{1'b0}};
      pend_r   <= {NrIrqs{1'b0}};
      trig_r   <= {NrIrqs{1'b0}};
      prev_r   <= {NrIrqs{1'b0}};
      thresh_r <= {PrioWidth{1'b0}};
      for (int i = 0; i < NrIrqs; i++) prio_r[i] <= {PrioWidth{1'b0}};
    end else begin
      prev_r <= ext_irqs_i;
      pend_r <= pend_nxt_s;
      for (int i = 0; i < NrIrqs; i++) begin
        if (line_wr_s[i]) begin
          prio_r[i] <= reg_wdata_i[PrioWidth-1:0];
          en_r[i]   <= reg_wdata_i[8];
          trig_r[i] <= reg_wdata_i[10];
        end
      end
      if (wr_s && thresh_sel_s) thresh_r <= reg_wdata_i[PrioWidth-1:0];
    end
  end

  // Nesting stack: ack pushes, ret pops, both together only swap the current level.
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      level_r <= {PrioWidth{1'b0}};
      depth_r <= {DepthWidth{1'b0}};
      for (int j = 0; j < NestDepth; j++) stack_r[j] <= {PrioWidth{1'b0}};
    end else if (ack_s && ret_s) begin
      level_r <= irq_level_o;
    end else if (ack_s) begin
      for (int j = 0; j < NestDepth; j++) begin
        if (depth_r == DepthWidth'(j)) stack_r[j] <= level_r;
      end
      level_r <= irq_level_o;
      depth_r <= depth_r + DepthWidth'(1);
    end else if (ret_s) begin
      level_r <= top_s;
      depth_r <= depth_r - DepthWidth'(1);
    end else begin
      level_r <= level_r;
    end
  end

  // Registered core handshake outputs and register response.
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      irq_valid_o  <= 1'b0;
      irq_id_o     <= {IrqWidth{1'b0}};
      irq_level_o  <= {PrioWidth{1'b0}};
      irq_nest_o   <= 1'b0;
      reg_rvalid_o <= 1'b0;
      reg_rdata_o  <= 32'd0;
    end else begin
      if (ack_s || !arb_valid_s) begin
        irq_valid_o <= 1'b0;
        irq_id_o    <= {IrqWidth{1'b0}};
        irq_level_o <= {PrioWidth{1'b0}};
        irq_nest_o  <= 1'b0;
      end else begin
        irq_valid_o <= 1'b1;
        irq_id_o    <= best_id_s;
        irq_level_o <= best_prio_s;
        irq_nest_o  <= (depth_r != {DepthWidth{1'b0}});
      end
      reg_rvalid_o <= reg_req_i;
      reg_rdata_o  <= rd_s ? rd_val_s : 32'd0;
    end
  end
endmodule
